// File: rtl/lcd_sched_pkg.sv
// Shared state encoding and parameter defaults
// for the LCD request scheduler.
package lcd_sched_pkg;

   localparam int N_REQ_DEF     = 4;
   localparam int CMD_W_DEF     = 8;
   localparam int TIMEOUT_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } sched_state_t;

endpackage

// File: rtl/req_edge_sync.sv
// Two-flop synchroniser for one async request level,
// followed by an edge register giving a 1-cycle rise pulse.
module req_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic req,
   output logic pulse
);

   logic s0;
   logic s1;
   logic s2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s0 <= 1'b0;
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s0 <= req;
         s1 <= s0;
         s2 <= s1;
      end
   end

   assign pulse = s1 & ~s2;

endmodule

// File: rtl/lcd_req_scheduler.sv
// Round-robin owner of the LCD SPI master: latches request edges,
// issues one command at a time and watches for a stuck transfer.
module lcd_req_scheduler
   import lcd_sched_pkg::*;
#(
   parameter int N_REQ     = N_REQ_DEF,
   parameter int CMD_W     = CMD_W_DEF,
   parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       req_i,
   input  logic [N_REQ*CMD_W-1:0] req_cmd_i,
   input  logic                   spi_busy_i,
   input  logic                   spi_done_i,
   output logic                   spi_start_o,
   output logic [CMD_W-1:0]       spi_cmd_o,
   output logic [N_REQ-1:0]       grant_o,
   output logic [N_REQ-1:0]       pending_o,
   output logic [N_REQ-1:0]       drop_o,
   output logic                   timeout_o
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   sched_state_t         state;
   logic [PW-1:0]        rr;
   logic [TIMEOUT_W-1:0] wd;

   logic [N_REQ-1:0] edge_v;
   logic [N_REQ-1:0] rot;
   logic [N_REQ-1:0] clr;
   logic [N_REQ-1:0] sel;
   logic [PW-1:0]    off;
   logic [PW-1:0]    win;
   logic [PW-1:0]    rr_nxt;
   logic             take;
   logic             expired;

   for (genvar g = 0; g < N_REQ; g++) begin : g_sync
      req_edge_sync u_sync (
         .clk   (clk),
         .rst   (rst),
         .req   (req_i[g]),
         .pulse (edge_v[g])
      );
   end

   // Rotate so rr sits at bit 0, take lowest set bit, rotate back.
   always_comb begin
      int idx;
      int sum;
      idx = 0;
      sum = 0;
      rot = '0;
      off = '0;
      for (int j = 0; j < N_REQ; j++) begin
         idx = j + int'(rr);
         if (idx >= N_REQ) idx -= N_REQ;
         rot[j] = pending_o[idx];
      end
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (rot[k]) off = PW'(k);
      end
      sum = int'(off) + int'(rr);
      if (sum >= N_REQ) sum -= N_REQ;
      win = PW'(sum);
   end

   assign rr_nxt  = (win == PW'(N_REQ - 1)) ? '0 : win + PW'(1);
   assign take    = (state == IDLE) && (|pending_o);
   assign sel     = N_REQ'(1) << win;
   assign clr     = take ? sel : '0;
   assign expired = &wd;

   assign spi_start_o = (state == ISSUE) && !spi_busy_i;
   assign timeout_o   = (state == WAIT) && expired && !spi_done_i;

   // A fresh edge on the bit being granted re-arms it rather than dropping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending_o <= '0;
         drop_o    <= '0;
      end else begin
         pending_o <= (pending_o & ~clr) | edge_v;
         drop_o    <= drop_o | (edge_v & pending_o & ~clr);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         rr        <= '0;
         wd        <= '0;
         grant_o   <= '0;
         spi_cmd_o <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (take) begin
                  grant_o   <= sel;
                  spi_cmd_o <= req_cmd_i[int'(win)*CMD_W +: CMD_W];
                  rr        <= rr_nxt;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (!spi_busy_i) begin
                  wd    <= '0;
                  state <= WAIT;
               end
            end
            WAIT: begin
               wd <= wd + TIMEOUT_W'(1);
               if (spi_done_i || expired) begin
                  grant_o <= '0;
                  state   <= IDLE;
               end
            end
            default: begin
               grant_o <= '0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule
